// File: rtl/seq_detect_nested.sv
// seq_detect_nested: nested serial-pattern detector for use under a controller FSM.
// A parent FSM (IDLE/DETECT/DONE) arms a child detector on start, counts matches
// of a runtime-loaded PAT_W-bit pattern (MSB first), and hands control back with
// a done pulse after MATCH_TARGET matches, or a timeout pulse when no match
// completes within TIMEOUT_CYC detect cycles. abort cancels silently.
module seq_detect_nested #(
    parameter int PAT_W        = 3,
    parameter int MATCH_TARGET = 1,
    parameter int OVERLAP      = 1,
    parameter int TIMEOUT_CYC  = 0,
    parameter int TO_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic             in,
    output logic             busy,
    output logic             match,
    output logic [7:0]       match_cnt,
    output logic             done,
    output logic             timeout
);

    localparam int                FILL_W     = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);
    localparam logic [7:0]        CNT_TARGET = 8'(MATCH_TARGET);
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT_CYC);
    localparam bit                TO_EN      = (TIMEOUT_CYC != 0);
    localparam bit                OVL_EN     = (OVERLAP != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DETECT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;
    // Only the last PAT_W-1 bits need storing; the full window is formed with
    // the incoming bit each cycle.
    logic [PAT_W-2:0]   hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [7:0]         match_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               busy_q;
    logic               match_q;
    logic               done_q;
    logic               timeout_q;

    logic [PAT_W-1:0]   window_d;
    logic [FILL_W-1:0]  fill_d;
    logic [7:0]         match_cnt_d;
    logic [TO_W-1:0]    to_cnt_d;
    logic               hit_d;
    logic               target_d;
    logic               expire_d;

    // Detect-cycle datapath: shifted window, saturating fill, match and expiry.
    // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
    always_comb begin
        window_d    = {hist_q, in};
        fill_d      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit_d       = (window_d == pat_q) && (fill_d == FILL_FULL);
        match_cnt_d = match_cnt_q + 8'd1;
        target_d    = (match_cnt_d == CNT_TARGET);
        to_cnt_d    = to_cnt_q + TO_W'(1);
        expire_d    = TO_EN && (to_cnt_d == TO_LIMIT);
    end

    // Parent FSM with child detector state and registered outputs.
    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            // NOTE: the latched pattern is reset too, so no register powers up unknown.
            pat_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            to_cnt_q    <= '0;
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (abort) begin
                // Cancel wins over start, match, done and timeout; counts are held.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            pat_q       <= pattern;
                            hist_q      <= '0;
                            fill_q      <= '0;
                            match_cnt_q <= '0;
                            to_cnt_q    <= '0;
                            state_q     <= S_DETECT;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_DETECT: begin
                        hist_q <= window_d[PAT_W-2:0];
                        if (hit_d) begin
                            // A match beats a same-edge timeout and restarts the timer.
                            match_q     <= 1'b1;
                            match_cnt_q <= match_cnt_d;
                            to_cnt_q    <= '0;
                            fill_q      <= OVL_EN ? fill_d : '0;
                            if (target_d) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            fill_q <= fill_d;
                            if (TO_EN) begin
                                to_cnt_q <= to_cnt_d;
                                if (expire_d) begin
                                    timeout_q <= 1'b1;
                                    state_q   <= S_IDLE;
                                    busy_q    <= 1'b0;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = match_cnt_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule
